vga_frame_signature: RTL

- Synthesizable per-frame signature generator for a VGA RGB stream. It is the successor to the simulation-only tiff frame dump.
- Taps the top-level vs/r/g/b outputs and accumulates one signature per frame, over a parametrised number of colour channels of parametrised width.
- Two accumulation modes: CRC-32 or additive checksum.
- Flags frame-length errors and mismatches against an expected signature, so benches and on-board debug can check gameplay frames without image files.

---
 rtl/vga_sig_pkg.sv | 34 +++
 rtl/vga_frame_signature_sig_accum.sv | 45 ++++
 rtl/vga_frame_signature.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/vga_sig_pkg.sv
// Shared types and CRC-32 helper for the VGA frame signature block.
// Holds the FSM state encoding and the MSB-first CRC-32 step.
package vga_sig_pkg;

   localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
   localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;
   localparam int          CRC_MAX_W  = 64;

   typedef enum logic [1:0] {
      IDLE,
      SKIP,
      RUN
   } sig_state_t;

   // Folds the low 'width' bits of data into crc, most significant bit first.
   function automatic logic [31:0] crc32_step(
      input logic [31:0]          crc,
      input logic [CRC_MAX_W-1:0] data,
      input int                   width
   );
      logic [31:0] c;
      logic        fb;
      c  = crc;
      fb = 1'b0;
      for (int i = CRC_MAX_W - 1; i >= 0; i--) begin
         if (i < width) begin
            fb = c[31] ^ data[i];
            c  = {c[30:0], 1'b0} ^ (fb ? CRC32_POLY : 32'h0);
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/vga_frame_signature_sig_accum.sv
// Per-frame accumulator: CRC-32 (MODE=0) or 32-bit wrap-around sum (MODE=1).
// clear restarts from the initial value and folds data in the same cycle.
module sig_accum
   import vga_sig_pkg::*;
#(
   parameter int MODE = 0,
   parameter int D    = 12
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         fold,
   input  logic [D-1:0] data,
   output logic [31:0]  acc
);

   localparam logic [31:0] INIT = (MODE == 0) ? CRC32_INIT : 32'h0;

   logic [31:0] acc_q;
   logic [31:0] acc_d;
   logic [31:0] base;

   always_comb begin
      acc_d = acc_q;
      base  = clear ? INIT : acc_q;
      if (clear || fold) begin
         if (MODE == 0) begin
            acc_d = crc32_step(base, CRC_MAX_W'(data), D);
         end else begin
            acc_d = base + 32'(data);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q <= INIT;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/vga_frame_signature.sv
// Per-frame signature generator tapping a VGA vs/pixel stream.
// Emits one registered signature per frame with length and compare flags.
module vga_frame_signature
   import vga_sig_pkg::*;
#(
   parameter int XDIM        = 1344,
   parameter int YDIM        = 806,
   parameter int COLOR_W     = 4,
   parameter int CHANNELS    = 3,
   parameter int MODE        = 0,
   parameter bit VS_ACTIVE   = 1'b0,
   parameter int SKIP_FRAMES = 1,
   parameter int FCNT_W      = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic                         vs,
   input  logic [CHANNELS*COLOR_W-1:0]  pix,
   input  logic [31:0]                  exp_sig,
   input  logic                         cmp_en,
   output logic [31:0]                  sig,
   output logic                         sig_valid,
   output logic [FCNT_W-1:0]            frame_cnt,
   output logic                         len_err,
   output logic                         mismatch
);

   localparam int D     = CHANNELS * COLOR_W;
   localparam int NPIX  = XDIM * YDIM;
   localparam int CNT_W = $clog2(NPIX + 2);
   localparam int SKP_W = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;

   localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(NPIX);
   localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(NPIX + 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [SKP_W-1:0] SKIP_LOAD = SKP_W'(SKIP_FRAMES);
   localparam logic [SKP_W-1:0] SKIP_ONE  = SKP_W'(1);

   sig_state_t        state_q, state_d;
   logic              vs_q;
   logic [SKP_W-1:0]  skip_q, skip_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       sig_q, sig_d;
   logic              sig_valid_q, sig_valid_d;
   logic              len_err_q, len_err_d;
   logic              mismatch_q, mismatch_d;
   logic [FCNT_W-1:0] fcnt_q, fcnt_d;

   logic        boundary;
   logic        acc_clear;
   logic        acc_fold;
   logic [31:0] acc;

   sig_accum #(
      .MODE (MODE),
      .D    (D)
   ) u_accum (
      .clk   (clk),
      .rst   (rst),
      .clear (acc_clear),
      .fold  (acc_fold),
      .data  (pix),
      .acc   (acc)
   );

   always_comb begin
      boundary    = (vs == VS_ACTIVE) && (vs_q != VS_ACTIVE);
      state_d     = state_q;
      skip_d      = skip_q;
      cnt_d       = cnt_q;
      sig_d       = sig_q;
      sig_valid_d = 1'b0;
      len_err_d   = 1'b0;
      mismatch_d  = 1'b0;
      fcnt_d      = fcnt_q;
      acc_clear   = 1'b0;
      acc_fold    = 1'b0;

      if (boundary) begin
         // The boundary pixel opens the next frame.
         acc_clear = 1'b1;
         cnt_d     = CNT_ONE;
         unique case (state_q)
            IDLE: begin
               if (en) begin
                  skip_d  = SKIP_LOAD;
                  state_d = (SKIP_FRAMES > 0) ? SKIP : RUN;
               end
            end
            SKIP: begin
               skip_d = skip_q - SKIP_ONE;
               if (skip_q <= SKIP_ONE) begin
                  state_d = RUN;
               end
            end
            RUN: begin
               sig_d       = acc;
               sig_valid_d = 1'b1;
               len_err_d   = (cnt_q != CNT_FULL);
               mismatch_d  = cmp_en && (acc != exp_sig);
               fcnt_d      = fcnt_q + 1'b1;
               if (!en) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end else if (state_q != IDLE) begin
         acc_fold = 1'b1;
         if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         vs_q        <= ~VS_ACTIVE;
         skip_q      <= '0;
         cnt_q       <= '0;
         sig_q       <= '0;
         sig_valid_q <= 1'b0;
         len_err_q   <= 1'b0;
         mismatch_q  <= 1'b0;
         fcnt_q      <= '0;
      end else begin
         state_q     <= state_d;
         vs_q        <= vs;
         skip_q      <= skip_d;
         cnt_q       <= cnt_d;
         sig_q       <= sig_d;
         sig_valid_q <= sig_valid_d;
         len_err_q   <= len_err_d;
         mismatch_q  <= mismatch_d;
         fcnt_q      <= fcnt_d;
      end
   end

   assign sig       = sig_q;
   assign sig_valid = sig_valid_q;
   assign frame_cnt = fcnt_q;
   assign len_err   = len_err_q;
   assign mismatch  = mismatch_q;

endmodule
